// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding and frame constants for the UART receiver
//
// Purpose : one place for the receiver FSM encoding (same encoding as the
//           transmitter, so the two can be probed with the same decode) and
//           the line levels that define an 8N1-style frame.
// Ports   : none (package).

package uart_rx_pkg;

  // Frame-walk states. The encoding is shared with the transmitter.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_DATA  = 2'b10,
    ST_STOP  = 2'b11
  } uart_state_e;

  // Default frame geometry.
  localparam int DEFAULT_DATA_BITS     = 8;
  localparam int DEFAULT_TICKS_PER_BIT = 16;

  // Line levels.
  localparam logic LINE_IDLE_LEVEL = 1'b1;
  localparam logic START_LEVEL     = 1'b0;
  localparam logic STOP_LEVEL      = 1'b1;

endpackage : uart_rx_pkg

// File: rtl/uart_rx_sync_2ff.sv
// rtl/uart_rx_sync_2ff.sv - generic 1-bit two-flop synchroniser with configurable reset value
//
// Purpose : brings an asynchronous 1-bit signal (serial line, button) into
//           the i_clk domain. Adds two cycles of latency.
// Ports   :
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset; both flops load RESET_VAL
//   i_d     - asynchronous input
//   o_q     - synchronised output

module uart_rx_sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule : uart_rx_sync_2ff

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver, 1 start / DATA_BITS data (LSB first) / 1 stop, no parity
//
// Purpose : deserialises frames from the RX pin using the shared baud tick
//           enable and hands each byte to the command parser with a
//           one-cycle done strobe.
// Ports   :
//   i_clk       - system clock
//   i_rst_n     - asynchronous active-low reset
//   i_tick_en   - oversampling tick, TICKS_PER_BIT pulses per bit period
//   i_rx        - raw asynchronous serial line, idle high
//   o_data      - last received byte, held until the next frame completes
//   o_rx_done   - one-cycle pulse per completed frame (good or bad)
//   o_frame_err - one-cycle pulse with o_rx_done when the stop bit sampled 0
//   o_busy      - high whenever the receiver is not idle

module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS     = DEFAULT_DATA_BITS,
  parameter int TICKS_PER_BIT = DEFAULT_TICKS_PER_BIT
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_tick_en,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_rx_done,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TICK_W = $clog2(TICKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);

  // Start bit is judged half a bit in; every later sample is one full bit
  // after the previous one, so all samples sit near bit centres.
  localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(TICKS_PER_BIT / 2 - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);
  localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  logic                 rx_s;
  uart_state_e          state_q;
  logic [TICK_W-1:0]    tick_cnt_q;
  logic [BIT_W-1:0]     bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 rx_done_q;
  logic                 frame_err_q;

  uart_rx_sync_2ff #(
    .RESET_VAL (LINE_IDLE_LEVEL)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      // Strobes are single-cycle unless the stop-bit branch re-raises them.
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          // Edge detection runs every clock, not just on ticks, so the
          // start-bit phase error is at most one tick period.
          if (rx_s == START_LEVEL) begin
            state_q    <= ST_START;
            tick_cnt_q <= '0;
          end
        end

        ST_START: begin
          if (i_tick_en) begin
            if (tick_cnt_q == TICK_MID) begin
              if (rx_s == START_LEVEL) begin
                state_q    <= ST_DATA;
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
              end else begin
                // Line went back high before mid-start: a glitch, not a frame.
                state_q <= ST_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_ONE;
            end
          end
        end

        ST_DATA: begin
          if (i_tick_en) begin
            if (tick_cnt_q == TICK_LAST) begin
              // Shifting in at the MSB leaves LSB-first data in bit order.
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              tick_cnt_q <= '0;
              if (bit_cnt_q == BIT_LAST) begin
                state_q <= ST_STOP;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_ONE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_ONE;
            end
          end
        end

        ST_STOP: begin
          if (i_tick_en) begin
            if (tick_cnt_q == TICK_LAST) begin
              // Byte is delivered even on a bad stop bit; the parser decides
              // what to do with it. Leaving at mid-stop gives half a bit of
              // margin to catch a back-to-back start edge.
              data_q      <= shift_q;
              rx_done_q   <= 1'b1;
              frame_err_q <= (rx_s != STOP_LEVEL);
              state_q     <= ST_IDLE;
              tick_cnt_q  <= '0;
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_ONE;
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_data      = data_q;
  assign o_rx_done   = rx_done_q;
  assign o_frame_err = frame_err_q;
  assign o_busy      = (state_q != ST_IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx

module tb_uart_rx;

  localparam int DATA_BITS     = 8;
  localparam int TICKS_PER_BIT = 16;
  localparam int CLKS_PER_TICK = 4;
  localparam int BIT_CLKS      = TICKS_PER_BIT * CLKS_PER_TICK;

  logic       clk;
  logic       rst_n;
  logic       tick_en;
  logic       rx;
  logic [7:0] data;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  int checks;
  int errors;
  int pulse_viol;
  logic prev_done;
  logic [8:0] got_q[$];

  uart_rx #(
    .DATA_BITS     (DATA_BITS),
    .TICKS_PER_BIT (TICKS_PER_BIT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_tick_en   (tick_en),
    .i_rx        (rx),
    .o_data      (data),
    .o_rx_done   (rx_done),
    .o_frame_err (frame_err),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared baud tick: one clock high every CLKS_PER_TICK clocks.
  initial begin
    tick_en = 1'b0;
    forever begin
      repeat (CLKS_PER_TICK - 1) @(posedge clk);
      #1 tick_en = 1'b1;
      @(posedge clk);
      #1 tick_en = 1'b0;
    end
  end

  // Record every completed frame as {frame_err, data}; flag strobes that are
  // wider than one cycle or an error strobe without done.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (rx_done === 1'b1) got_q.push_back({frame_err, data});
    if (rx_done === 1'b1 && prev_done === 1'b1) pulse_viol = pulse_viol + 1;
    if (frame_err === 1'b1 && rx_done !== 1'b1) pulse_viol = pulse_viol + 1;
    prev_done = rx_done;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bench-side transmitter. A low stop bit is held only 48 clocks so the
  // receiver's re-armed start detection sees the line high at mid-start.
  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(BIT_CLKS);
    end
    rx = stop;
    if (stop) begin
      wait_clks(BIT_CLKS);
    end else begin
      wait_clks(48);
      rx = 1'b1;
      wait_clks(BIT_CLKS - 48);
    end
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] exp_data, input logic exp_err);
    logic [8:0] got;
    got = 9'bx;
    if (got_q.size() > 0) got = got_q.pop_front();
    check(tag, {23'd0, got}, {23'd0, exp_err, exp_data});
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pulse_viol = 0;
    rst_n      = 1'b0;
    rx         = 1'b1;
    wait_clks(5);

    check("reset_data", {24'd0, data}, 32'h00);
    check("reset_done", {31'd0, rx_done}, 32'd0);
    check("reset_ferr", {31'd0, frame_err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);

    rst_n = 1'b1;
    wait_clks(20);

    // 1: good frame 0xA5
    send_byte(8'hA5, 1'b1);
    expect_frame("t1_frame", 8'hA5, 1'b0);
    check("t1_odata", {24'd0, data}, 32'hA5);
    check("t1_busy_after", {31'd0, busy}, 32'd0);

    // 2: 5-tick glitch is rejected, then 0x3C
    rx = 1'b0;
    wait_clks(5 * CLKS_PER_TICK);
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("t2_no_done", got_q.size(), 32'd0);
    check("t2_idle", {31'd0, busy}, 32'd0);
    check("t2_hold", {24'd0, data}, 32'hA5);
    send_byte(8'h3C, 1'b1);
    expect_frame("t2_frame", 8'h3C, 1'b0);

    // 3: stop bit held low -> framing error, data still delivered
    send_byte(8'h3C, 1'b0);
    expect_frame("t3_frame_err", 8'h3C, 1'b1);
    check("t3_odata", {24'd0, data}, 32'h3C);
    wait_clks(2 * BIT_CLKS);
    check("t3_no_extra", got_q.size(), 32'd0);
    check("t3_idle", {31'd0, busy}, 32'd0);

    // 4: back-to-back 0x00 then 0xFF
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    expect_frame("t4_first", 8'h00, 1'b0);
    expect_frame("t4_second", 8'hFF, 1'b0);
    check("t4_odata", {24'd0, data}, 32'hFF);

    // 5: reset during data bit 3 of 0x5A
    rx = 1'b0;
    wait_clks(BIT_CLKS);
    rx = 1'b0; wait_clks(BIT_CLKS);  // bit0
    rx = 1'b1; wait_clks(BIT_CLKS);  // bit1
    rx = 1'b0; wait_clks(BIT_CLKS);  // bit2
    rx = 1'b1; wait_clks(BIT_CLKS / 2);  // half of bit3
    check("t5_busy_midframe", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_data", {24'd0, data}, 32'h00);
    check("t5_rst_done", {31'd0, rx_done}, 32'd0);
    check("t5_rst_ferr", {31'd0, frame_err}, 32'd0);
    check("t5_rst_busy", {31'd0, busy}, 32'd0);
    wait_clks(10);
    rx    = 1'b1;
    rst_n = 1'b1;
    wait_clks(3 * BIT_CLKS);
    check("t5_no_done", got_q.size(), 32'd0);
    send_byte(8'h5A, 1'b1);
    expect_frame("t5_frame", 8'h5A, 1'b0);

    // 6: loopback-style sweep through the bench transmitter
    for (int v = 0; v < 256; v += 7) begin
      send_byte(8'(v), 1'b1);
      expect_frame("t6_sweep", 8'(v), 1'b0);
    end

    check("pulse_width", pulse_viol, 32'd0);
    check("no_leftover", got_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver paired with the existing transmitter. It deserialises an 8N1-style frame from the asynchronous serial line using the shared oversampling tick enable (TICKS_PER_BIT ticks per bit) and presents each byte with a one-cycle done strobe. It sits between the board RX pin and the calculator's command/input parser. Frame format: 1 start bit (0), DATA_BITS data bits LSB first, 1 stop bit (1), no parity.

Parameters:
DATA_BITS, 8, number of data bits per frame (≥2)
TICKS_PER_BIT, 16, tick-enable pulses per bit period (even, ≥4)

Ports:
i_clk  input  1  system clock; all state changes on its rising edge
i_rst_n  input  1  asynchronous, active-low reset
i_tick_en  input  1  oversampling tick enable from the shared baud generator
i_rx  input  1  raw asynchronous serial line, idle high
o_data  output  DATA_BITS  last received byte; registered; holds until the next frame completes
o_rx_done  output  1  one-cycle pulse when a frame completes (good or bad)
o_frame_err  output  1  one-cycle pulse coincident with o_rx_done when the sampled stop bit is 0
o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE, counters=0, shift buffer=0, both synchroniser flops=1, o_data=0, o_rx_done=0, o_frame_err=0, o_busy=0.
- i_rx passes through a 2-flop synchroniser (reset value 1); all decisions use the synchronised bit rx_s. Adds 2 cycles of input latency.
- Counter widths: tick counter is $clog2(TICKS_PER_BIT) bits; bit counter is $clog2(DATA_BITS) bits. Increments wrap-free by construction.
- While i_tick_en is low, counters and state hold. Exception: the IDLE→START transition does not need a tick.
- IDLE: if rx_s==0, go to START and set tick_cnt=0.
- START: on each tick, if tick_cnt==TICKS_PER_BIT/2-1 (mid start bit):
  - rx_s==0 → go to DATA, tick_cnt=0, bit_cnt=0.
  - rx_s==1 → glitch; return to IDLE. No outputs change.
  - Otherwise tick_cnt++.
- DATA: on each tick, if tick_cnt==TICKS_PER_BIT-1 (mid data bit):
  - Shift rx_s into the MSB of the buffer (buffer = {rx_s, buffer[DATA_BITS-1:1]}), so LSB-first data lands in bit order. Set tick_cnt=0.
  - If bit_cnt==DATA_BITS-1 → go to STOP; else bit_cnt++.
  - Otherwise tick_cnt++.
- STOP: on each tick, if tick_cnt==TICKS_PER_BIT-1 (mid stop bit):
  - Next cycle: o_data ← buffer, o_rx_done=1, o_frame_err=~rx_s.
  - Go to IDLE.
  - Otherwise tick_cnt++.
- Returning to IDLE at mid-stop lets a back-to-back frame's start edge be caught with half a bit of margin.
- On a framing error, o_data is still updated. If the line is held low (break), the next frame simply restarts from IDLE.
- Outputs are registered; o_rx_done and o_frame_err are high for exactly one i_clk cycle per frame.
- Reset asserted mid-frame aborts immediately. The partial byte is discarded and no done pulse is issued.
- i_rx transitions during the clock cycle are tolerated by the synchroniser. There are no simultaneous-event conflicts, since the only input handshake is the tick.

Decomposition:
- Shared package/header: state encodings IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11 (same as the transmitter); frame-level constants.
- One sub-module is natural: sync_2ff (generic 1-bit two-flop synchroniser with reset value parameter), reusable for other async inputs (buttons).

Test Plan:
(All cases: TICKS_PER_BIT=16, tick every 4 clocks, DATA_BITS=8.)
1. Send 0xA5 with a valid stop bit → o_data=0xA5, o_rx_done pulses exactly 1 cycle, o_frame_err=0, o_busy falls after the pulse.
2. Drive i_rx low for 5 ticks, then high → no o_rx_done, state returns to IDLE. A subsequent 0x3C frame is received as 0x3C.
3. Send 0x3C with the stop bit held 0 → o_rx_done=1 and o_frame_err=1 in the same cycle, o_data=0x3C.
4. Send back-to-back 0x00 then 0xFF with no idle gap → two done pulses, o_data=0x00 then 0xFF, no frame errors.
5. Assert i_rst_n low during data bit 3 of 0x5A → all outputs 0 immediately, no done pulse. After release, 0x5A is received correctly.
6. Loopback with the transmitter: i_rx ← o_tx, send 0x00..0xFF → every byte matches, 256 done pulses, zero frame errors.
